// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// Results that do not fit in BCD_DIGITS saturate to all nines and set o_overflow.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for i_start; the last result is held on the outputs
// S_SHIFT | BIN_W adjust+shift steps, then one cycle to publish the result
module bin2bcd_seq #(
    parameter int BIN_W      = 12,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [BIN_W-1:0]        i_bin_in,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd_out,
    output logic                    o_overflow
);

    // Scratch is sized from BIN_W rather than BCD_DIGITS, so the overflow
    // decision always sees the full decimal value.
    localparam int SCR_D = (BIN_W + 2) / 3 + 1;
    localparam int SCR_W = 4 * SCR_D;
    localparam int OUT_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [OUT_W-1:0] NINES = {BCD_DIGITS{4'h9}};

    logic [0:0]             r_state;
    logic [BIN_W-1:0]       r_shift;
    logic [SCR_W-1:0]       r_scr;
    logic [CNT_W-1:0]       r_cnt;
    logic [OUT_W-1:0]       r_bcd;
    logic                   r_ovf;
    logic                   r_done;

    logic [SCR_W-1:0]       w_adj;
    logic [SCR_W+BIN_W-1:0] w_cat;
    logic [OUT_W-1:0]       w_low;
    logic                   w_hi_nz;

    always_comb begin
        w_adj = r_scr;
        for (int d = 0; d < SCR_D; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_cat   = {w_adj, r_shift} << 1;
    assign w_hi_nz = |(r_scr >> OUT_W);

    // Output digits beyond the scratch width (large BCD_DIGITS) read as zero.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_low
        if (g < SCR_D) begin : g_in
            assign w_low[4*g +: 4] = r_scr[4*g +: 4];
        end else begin : g_pad
            assign w_low[4*g +: 4] = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift <= i_bin_in;
                        r_scr   <= '0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_scr   <= w_cat[SCR_W+BIN_W-1:BIN_W];
                        r_shift <= w_cat[BIN_W-1:0];
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end else begin
                        r_bcd   <= w_hi_nz ? NINES : w_low;
                        r_ovf   <= w_hi_nz;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == S_SHIFT);
    assign o_done     = r_done;
    assign o_bcd_out  = r_bcd;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three instances (12/3, 8/2, 12/4) checked against
// an arithmetic decimal model, with directed, random and exhaustive inputs.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sa = 1'b0, sb = 1'b0, sc = 1'b0;
    logic [11:0] ba = '0;
    logic [7:0]  bb = '0;
    logic [11:0] bc = '0;

    logic        busy_a, done_a, ov_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ov_b;
    logic [7:0]  bcd_b;
    logic        busy_c, done_c, ov_c;
    logic [15:0] bcd_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(12), .BCD_DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start(sa), .i_bin_in(ba),
        .o_busy(busy_a), .o_done(done_a), .o_bcd_out(bcd_a), .o_overflow(ov_a));

    bin2bcd_seq #(.BIN_W(8), .BCD_DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(sb), .i_bin_in(bb),
        .o_busy(busy_b), .o_done(done_b), .o_bcd_out(bcd_b), .o_overflow(ov_b));

    bin2bcd_seq #(.BIN_W(12), .BCD_DIGITS(4)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start(sc), .i_bin_in(bc),
        .o_busy(busy_c), .o_done(done_c), .o_bcd_out(bcd_c), .o_overflow(ov_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Decimal reference: bit 40 is the overflow flag, low nibbles the digits.
    function automatic logic [40:0] model(input longint v, input int digits);
        logic [40:0] r = '0;
        longint lim = 1;
        longint x = v;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
            r[40] = 1'b1;
        end else begin
            for (int i = 0; i < digits; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic int bad_nibbles(input logic [39:0] x, input int digits);
        int n = 0;
        for (int i = 0; i < digits; i++) if (x[4*i +: 4] > 4'd9) n++;
        return n;
    endfunction

    task automatic kick_a(input logic [11:0] v);
        ba = v; sa = 1'b1; @(posedge clk); #1 sa = 1'b0;
    endtask
    task automatic kick_b(input logic [7:0] v);
        bb = v; sb = 1'b1; @(posedge clk); #1 sb = 1'b0;
    endtask
    task automatic kick_c(input logic [11:0] v);
        bc = v; sc = 1'b1; @(posedge clk); #1 sc = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin lat = n - 1; break; end
        end
        chk("a_done_seen", done_a, 1'b1);
    endtask
    task automatic wait_b(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_b) begin lat = n - 1; break; end
        end
        chk("b_done_seen", done_b, 1'b1);
    endtask
    task automatic wait_c(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_c) begin lat = n - 1; break; end
        end
        chk("c_done_seen", done_c, 1'b1);
    endtask

    task automatic conv_a(input logic [11:0] v, input bit check_lat);
        int lat;
        logic [40:0] e;
        kick_a(v);
        wait_a(lat);
        e = model(longint'(v), 3);
        if (check_lat) chk("a_latency", lat, 13);
        chk("a_bcd", bcd_a, e[11:0]);
        chk("a_ovf", ov_a, e[40]);
    endtask

    task automatic conv_b(input logic [7:0] v, input bit check_lat);
        int lat;
        logic [40:0] e;
        kick_b(v);
        wait_b(lat);
        e = model(longint'(v), 2);
        if (check_lat) chk("b_latency", lat, 9);
        chk("b_bcd", bcd_b, e[7:0]);
        chk("b_ovf", ov_b, e[40]);
    endtask

    initial begin
        int lat;
        int cnt;
        logic [40:0] e;

        #1;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_bcd", bcd_a, 12'h000);
        chk("rst_ovf", ov_a, 1'b0);
        chk("rst_bcd_b", bcd_b, 8'h00);
        repeat (3) @(negedge clk);

        // Release reset and start in the same cycle: first edge must accept.
        rst_n = 1'b1;
        conv_a(12'd0, 1'b1);
        @(negedge clk);
        chk("a_done_pulse", done_a, 1'b0);
        chk("a_busy_after", busy_a, 1'b0);

        conv_a(12'd999, 1'b1);
        conv_a(12'd507, 1'b1);
        conv_a(12'd1000, 1'b1);
        conv_a(12'd4095, 1'b1);

        conv_b(8'd59, 1'b1);
        conv_b(8'd255, 1'b1);
        conv_b(8'd10, 1'b1);

        for (int i = 0; i < 40; i++) conv_a(12'($urandom_range(0, 4095)), 1'b0);
        for (int i = 0; i < 40; i++) conv_b(8'($urandom_range(0, 255)), 1'b0);

        // start and bin_in churn while busy must not disturb the conversion.
        kick_a(12'd123);
        repeat (3) @(negedge clk);
        sa = 1'b1; ba = 12'd456;
        @(negedge clk);
        chk("a_busy_mid", busy_a, 1'b1);
        ba = 12'($urandom);
        @(negedge clk);
        sa = 1'b0; ba = 12'($urandom);
        wait_a(lat);
        chk("a_ignore_start", bcd_a, 12'h123);

        // Back-to-back: start issued in the done cycle.
        kick_a(12'd456);
        wait_a(lat);
        chk("a_b2b_latency", lat, 13);
        chk("a_b2b_bcd", bcd_a, 12'h456);

        conv_a(12'd4000, 1'b0);
        kick_a(12'd777);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_bcd", bcd_a, 12'h000);
        chk("mid_rst_ovf", ov_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
        chk("mid_rst_no_done", cnt, 0);
        chk("mid_rst_hold", bcd_a, 12'h000);
        conv_a(12'd42, 1'b1);

        for (int v = 0; v < 4096; v++) begin
            kick_c(12'(v));
            wait_c(lat);
            e = model(longint'(v), 4);
            if (v == 0) chk("c_latency", lat, 13);
            chk("c_bcd", bcd_c, e[15:0]);
            chk("c_range", bad_nibbles({24'd0, bcd_c}, 4), 0);
            chk("c_ovf", ov_c, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
